data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Data-memory stage of the 8-bit Harvard CPU, directly downstream of the control unit.
//  - Consumes the CU's cmd_memory / addr_memory strobes; word storage is DEPTH x DATA_W.
//  - Shares the bidirectional data_memory bus with the CU: the CU drives it for writes,
//    this block drives it for reads.
//  - Adds a multi-cycle CLEAR sweep that zeroes the whole array, reported on busy.
// PARAMETERS
//  ADDR_W        8    address width; DEPTH = 2**ADDR_W
//  DATA_W        8    word width
//  CLR_ON_RESET  1    1: run a CLEAR sweep automatically after reset release; 0: no sweep
// PORTS
//  clk          in     1       system clock, all state updates on rising edge
//  rst_n        in     1       asynchronous reset, active low
//  cmd_memory   in     8       command from CU: 8'h00 READ, 8'h01 WRITE, 8'h02 CLEAR, others NOP
//  addr_memory  in     ADDR_W  word address
//  data_memory  inout  DATA_W  shared data bus; driven here only during READ, else 'z
//  busy         out    1       high while a CLEAR sweep is in progress
//  cmd_err      out    1       sticky command-while-busy flag (present only with DMEM_CMD_ERR_EN)
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - state=IDLE, clr_cnt=0, rdata=0, busy=0, cmd_err=0, bus released ('z).
//   - Array contents are NOT reset.
//  FSM states:
//   - IDLE -> CLEAR on a CLEAR command, or on the first edge after rst_n release when CLR_ON_RESET=1.
//   - CLEAR -> IDLE on the edge that writes address DEPTH-1.
//  IDLE, per rising edge, decoding cmd_memory:
//   - READ: rdata <= mem[addr_memory]. One-cycle latency: the value is valid on the bus after
//     that edge and held while cmd stays READ. The CU samples it on the following edge.
//   - WRITE: mem[addr_memory] <= data_memory, sampled at the edge. The bus is never driven
//     here while cmd=WRITE.
//   - CLEAR: next state CLEAR, clr_cnt <= 0, busy=1 from the next cycle.
//   - NOP (any other code): no state or array change; bus 'z.
//  Bus drive (combinational): data_memory = (state==IDLE && cmd_memory==8'h00) ? rdata : 'z.
//  CLEAR sweep:
//   - Each cycle: mem[clr_cnt] <= 0, clr_cnt++. Exactly DEPTH cycles.
//   - clr_cnt is ADDR_W+1 bits wide so the terminal count does not wrap to 0.
//   - busy falls on the same edge the FSM returns to IDLE.
//   - Incoming commands of any type are ignored during the sweep; bus stays 'z.
//  Boundaries:
//   - Address DEPTH-1 is valid for READ and WRITE. addr_memory wider bits do not exist.
//   - rst_n asserted mid-sweep: the sweep aborts immediately and the array is partially
//     cleared. With CLR_ON_RESET=1, a full sweep restarts from address 0 after release.
//   - A CLEAR command in the same cycle the sweep ends is ignored (state is not IDLE).
// CONFIGURATION
//  `DMEM_CMD_ERR_EN defined:
//   - cmd_err port exists.
//   - cmd_err is set on any non-NOP command received while state==CLEAR.
//   - cmd_err is cleared only by reset.
//  `DMEM_CMD_ERR_EN undefined:
//   - No cmd_err port.
//   - Commands received during busy are dropped silently.
// STRUCTURE
//  Package dmem_pkg:
//   - CMD_READ=8'h00, CMD_WRITE=8'h01, CMD_CLEAR=8'h02 (the CU's values).
//   - State encoding: ST_IDLE, ST_CLEAR.
//  Sub-module dmem_array:
//   - Storage: DEPTH x DATA_W, one synchronous write port, one synchronous read port, no reset.
//   - data_memory_ctrl owns the FSM, sweep counter, bus tristate and the optional error flag.
// TESTING
//  1. CLR_ON_RESET=1, release rst_n -> busy=1 for exactly 256 cycles, then 0.
//     READ of 8'h00, 8'h7F and 8'hFF all return 8'h00.
//  2. WRITE 8'hA5 @8'h10, then READ @8'h10 -> data_memory=8'hA5 one edge after the READ edge.
//     Bus is 'z during the WRITE cycle.
//  3. WRITE 8'h3C @8'hFF, then WRITE 8'h11 @8'h00 -> READ @8'hFF returns 8'h3C
//     (last address, no aliasing).
//  4. Issue CLEAR, then WRITE 8'h55 @8'h20 during busy -> write dropped, READ @8'h20 = 8'h00.
//     With DMEM_CMD_ERR_EN, cmd_err=1 and it remains 1.
//  5. cmd_memory=8'h07 with addr 8'h10 holding 8'hA5 -> bus 'z, array unchanged,
//     READ @8'h10 = 8'hA5.
//  6. Assert rst_n at sweep cycle 100 -> busy=0 and bus 'z immediately (async).
//     After release, the full 256-cycle sweep restarts from address 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - command codes, FSM states and decode helper for the data-memory stage
package dmem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic is_nop(input logic [7:0] cmd);
    return !((cmd == CMD_READ) || (cmd == CMD_WRITE) || (cmd == CMD_CLEAR));
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - CU-to-data-memory command bus (cmd_err only with DMEM_CMD_ERR_EN)
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        cmd_memory;
  logic [ADDR_W-1:0] addr_memory;
  logic              busy;
`ifdef DMEM_CMD_ERR_EN
  logic              cmd_err;

  modport master (output cmd_memory, output addr_memory, input busy, input cmd_err);
  modport slave  (input cmd_memory, input addr_memory, output busy, output cmd_err);
`else
  modport master (output cmd_memory, output addr_memory, input busy);
  modport slave  (input cmd_memory, input addr_memory, output busy);
`endif

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DATA_W storage, one sync write port, one sync read port
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Storage has no reset; only the read-data register does.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - data-memory stage: READ/WRITE/CLEAR decode, sweep FSM, bus tristate
// Optional sticky command-while-busy flag under DMEM_CMD_ERR_EN.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_ctrl_if.slave   bus_if,
  inout  wire  [DATA_W-1:0]   data_memory
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'((2**ADDR_W) - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_clr_cnt;
  logic              r_busy;
  logic              r_clr_pend;

  logic              w_idle;
  logic              w_decode;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign w_idle   = (r_state == ST_IDLE);
  // The post-reset sweep request pre-empts whatever the CU presents on that first edge.
  assign w_decode = w_idle && !r_clr_pend;
  assign w_re     = w_decode && (bus_if.cmd_memory == CMD_READ);
  assign w_we     = !w_idle || (w_decode && (bus_if.cmd_memory == CMD_WRITE));
  assign w_waddr  = w_idle ? bus_if.addr_memory : r_clr_cnt[ADDR_W-1:0];
  assign w_wdata  = w_idle ? data_memory : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_busy     <= 1'b0;
      r_clr_pend <= CLR_ON_RESET;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_clr_pend || (bus_if.cmd_memory == CMD_CLEAR)) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= '0;
            r_busy     <= 1'b1;
            r_clr_pend <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + CNT_ONE;
          if (r_clr_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (bus_if.addr_memory),
    .o_rdata (w_rdata)
  );

  assign data_memory = (w_idle && (bus_if.cmd_memory == CMD_READ)) ? w_rdata : 'z;
  assign bus_if.busy = r_busy;

`ifdef DMEM_CMD_ERR_EN
  logic r_cmd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_err <= 1'b0;
    end else if ((r_state == ST_CLEAR) && !is_nop(bus_if.cmd_memory)) begin
      r_cmd_err <= 1'b1;
    end
  end

  assign bus_if.cmd_err = r_cmd_err;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl with read scoreboard
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  localparam logic [7:0] CMD_NOP = 8'hFF;
  localparam logic [7:0] PROBE   = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_drv_en;
  logic [7:0] tb_drv;
  wire  [7:0] data_memory;

  int compared = 0;
  int mismatched = 0;
  int n_busy;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_W(8)) u_if ();

  assign data_memory = tb_drv_en ? tb_drv : 8'hzz;

  data_memory_ctrl #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .CLR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_if      (u_if),
    .data_memory (data_memory)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    u_if.cmd_memory  = CMD_NOP;
    u_if.addr_memory = 8'h00;
    tb_drv_en        = 1'b0;
    tb_drv           = 8'h00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    u_if.cmd_memory  = CMD_WRITE;
    u_if.addr_memory = a;
    tb_drv_en        = 1'b1;
    tb_drv           = d;
    @(negedge clk);
    chk($sformatf("bus_in_write@%02h", a), data_memory, d);
    idle_inputs();
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    u_if.cmd_memory  = CMD_READ;
    u_if.addr_memory = a;
    tb_drv_en        = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    chk($sformatf("read@%02h", a), data_memory, exp_q.pop_front());
    idle_inputs();
  endtask

  // Counts busy cycles (sampled at negedges), optionally injecting one command or a reset.
  task automatic sweep(input int inj_at, input logic [7:0] inj_cmd, input logic [7:0] inj_addr,
                       input logic [7:0] inj_data, input int rst_at, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!u_if.busy) break;
      n++;
      idle_inputs();
      if (n == inj_at) begin
        u_if.cmd_memory  = inj_cmd;
        u_if.addr_memory = inj_addr;
        if (inj_cmd == CMD_WRITE) begin
          tb_drv_en = 1'b1;
          tb_drv    = inj_data;
        end
      end
      if (n == rst_at) begin
        rst_n     = 1'b0;
        tb_drv_en = 1'b1;
        tb_drv    = PROBE;
        #1;
        chk("async_rst_busy", u_if.busy, 1'b0);
        chk("async_rst_bus_released", data_memory, PROBE);
        break;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tb_drv_en = 1'b1;
    tb_drv    = PROBE;
    repeat (3) @(negedge clk);
    chk("reset_busy", u_if.busy, 1'b0);
    chk("reset_bus_released", data_memory, PROBE);
`ifdef DMEM_CMD_ERR_EN
    chk("reset_cmd_err", u_if.cmd_err, 1'b0);
`endif

    // Automatic sweep after reset release
    idle_inputs();
    rst_n = 1'b1;
    sweep(0, CMD_NOP, 8'h00, 8'h00, 0, n_busy);
    chk("post_reset_sweep_len", n_busy, 256);
    rd(8'h00, 8'h00);
    rd(8'h7F, 8'h00);
    rd(8'hFF, 8'h00);

    wr(8'h10, 8'hA5);
    rd(8'h10, 8'hA5);

    wr(8'hFF, 8'h3C);
    wr(8'h00, 8'h11);
    rd(8'hFF, 8'h3C);
    rd(8'h00, 8'h11);

    // CLEAR with a write dropped mid-sweep and a CLEAR on the terminal edge
    u_if.cmd_memory = CMD_CLEAR;
    sweep(40, CMD_WRITE, 8'h20, 8'h55, 0, n_busy);
    chk("clear_sweep_len_a", n_busy, 256);
    u_if.cmd_memory = CMD_CLEAR;
    sweep(256, CMD_CLEAR, 8'h00, 8'h00, 0, n_busy);
    chk("clear_sweep_len_b", n_busy, 256);
    @(negedge clk);
    chk("clear_at_sweep_end_ignored", u_if.busy, 1'b0);
    rd(8'h20, 8'h00);
    rd(8'h00, 8'h00);
`ifdef DMEM_CMD_ERR_EN
    chk("cmd_err_set", u_if.cmd_err, 1'b1);
`endif

    // Undefined opcode: bus released, array untouched
    wr(8'h10, 8'hA5);
    rd(8'h10, 8'hA5);
    u_if.cmd_memory  = 8'h07;
    u_if.addr_memory = 8'h10;
    tb_drv_en        = 1'b1;
    tb_drv           = PROBE;
    @(negedge clk);
    chk("nop_bus_released", data_memory, PROBE);
    chk("nop_busy", u_if.busy, 1'b0);
    idle_inputs();
    rd(8'h10, 8'hA5);
`ifdef DMEM_CMD_ERR_EN
    chk("cmd_err_sticky", u_if.cmd_err, 1'b1);
`endif

    // Reset mid-sweep, then full restart
    wr(8'h00, 8'hAA);
    wr(8'hC8, 8'hAA);
    u_if.cmd_memory = CMD_CLEAR;
    sweep(0, CMD_NOP, 8'h00, 8'h00, 100, n_busy);
    chk("abort_at_cycle", n_busy, 100);
    repeat (2) @(negedge clk);
    chk("held_reset_busy", u_if.busy, 1'b0);
`ifdef DMEM_CMD_ERR_EN
    chk("cmd_err_cleared_by_reset", u_if.cmd_err, 1'b0);
`endif
    idle_inputs();
    rst_n = 1'b1;
    sweep(0, CMD_NOP, 8'h00, 8'h00, 0, n_busy);
    chk("restart_sweep_len", n_busy, 256);
    rd(8'h00, 8'h00);
    rd(8'hC8, 8'h00);
    rd(8'h10, 8'h00);
    rd(8'hFF, 8'h00);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
